// File: rtl/router_pkt_fifo_pkg.sv
// Shared constants for the router output FIFO: default sizes, header-tag position
// and header length-field slice.
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int LEN_LSB    = 2;

    // The header tag sits just above the payload bits of each stored word.
    function automatic int hdr_bit(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake bundle between the router FSM side and an output FIFO.
// Optional fill_level signal is present only when ROUTER_FIFO_LEVEL_EN is defined.
interface router_pkt_fifo_if
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) ();

    logic              write_enb;
    logic              read_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [DATA_W-2:0] pkt_remaining;
    logic              pkt_done;

`ifdef ROUTER_FIFO_LEVEL_EN
    localparam int ADDR_W = $clog2(DEPTH);
    logic [ADDR_W:0]   fill_level;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  dout, full, empty, almost_full, pkt_remaining, pkt_done, fill_level
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output dout, full, empty, almost_full, pkt_remaining, pkt_done, fill_level
    );
`else
    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  dout, full, empty, almost_full, pkt_remaining, pkt_done
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output dout, full, empty, almost_full, pkt_remaining, pkt_done
    );
`endif

endinterface

// File: rtl/router_pkt_fifo_ptr.sv
// Pointer pair and occupancy flags for the packet FIFO; decides which requests are accepted.
// Exposes fill_level only when ROUTER_FIFO_LEVEL_EN is defined.
module router_fifo_ptr #(
    parameter  int DEPTH    = 16,
    parameter  int AFULL_TH = DEPTH - 2,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    output logic              wr_ok,
    output logic              rd_ok,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              full,
    output logic              empty,
    output logic              almost_full
`ifdef ROUTER_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]   fill_level
`endif
);

    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] level;

    // The extra pointer MSB separates the wrapped-full case from empty.
    assign level       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign almost_full = (level >= AFULL_LVL);

    assign wr_ok   = write_enb && !full  && !soft_reset;
    assign rd_ok   = read_enb  && !empty && !soft_reset;
    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

`ifdef ROUTER_FIFO_LEVEL_EN
    assign fill_level = level;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO for the 1x3 router: tagged storage, registered read data and
// per-packet remaining-word tracking. ROUTER_FIFO_LEVEL_EN adds the fill_level output.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic soft_reset,
    router_pkt_fifo_if.slave bus
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int HDR_BIT = hdr_bit(DATA_W);
    localparam logic [DATA_W-2:0] REM_ONE = (DATA_W-1)'(1);

    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_ok;
    logic              rd_ok;
    logic              lfd_q;
    logic [DATA_W:0]   rd_word;
    logic [DATA_W-2:0] hdr_len;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-2:0] rem_q;
    logic              done_q;

    router_fifo_ptr #(
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) u_ptr (
        .clk         (clk),
        .rstn        (rstn),
        .soft_reset  (soft_reset),
        .write_enb   (bus.write_enb),
        .read_enb    (bus.read_enb),
        .wr_ok       (wr_ok),
        .rd_ok       (rd_ok),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .full        (bus.full),
        .empty       (bus.empty),
        .almost_full (bus.almost_full)
`ifdef ROUTER_FIFO_LEVEL_EN
        ,
        .fill_level  (bus.fill_level)
`endif
    );

    // lfd_state leads the header by one cycle, so it is delayed to line up with the write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           lfd_q <= 1'b0;
        else if (soft_reset) lfd_q <= 1'b0;
        else                 lfd_q <= bus.lfd_state;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= {lfd_q, bus.data_in};
    end

    assign rd_word = mem[rd_addr];
    // Header length counts payload bytes; the extra one accounts for the parity byte.
    assign hdr_len = {1'b0, rd_word[DATA_W-1:LEN_LSB]} + REM_ONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
        end else if (soft_reset) begin
            dout_q <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
        end else begin
            dout_q <= '0;
            done_q <= 1'b0;
            if (rd_ok) begin
                dout_q <= rd_word[DATA_W-1:0];
                if (rd_word[HDR_BIT]) begin
                    rem_q <= hdr_len;
                end else if (rem_q != '0) begin
                    rem_q  <= rem_q - REM_ONE;
                    done_q <= (rem_q == REM_ONE);
                end
            end
        end
    end

    assign bus.dout          = dout_q;
    assign bus.pkt_remaining = rem_q;
    assign bus.pkt_done      = done_q;

endmodule
